// File: rtl/kernel_sysid_pkg.sv
// Shared types and constants for the boot-time sysid checker.
package kernel_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_ID = 3'd1,
        ST_RD_TS = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } sysid_state_t;

    localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd2;
    localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1504027687;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/kernel_sysid_checker.sv
// Reads the sysid ID and timestamp words at boot, compares them with build-time
// values, retries a bounded number of passes, and reports flags and captured words.
module kernel_sysid_checker
    import kernel_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
    parameter int unsigned READ_LATENCY       = 0,
    parameter int unsigned RETRY_MAX          = 3
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    output logic         sysid_address,
    input  logic [31:0]  sysid_readdata,
    output logic         busy,
    output logic         done,
    output logic         id_ok,
    output logic         ts_ok,
    output logic [31:0]  id_value,
    output logic [31:0]  ts_value,
    output logic [3:0]   attempts,
    output sysid_state_t fsm_state
);

    // Handshake: start is a level request sampled only in IDLE; done is a
    // one-cycle pulse; busy is high from the accepting edge until back in IDLE.

    localparam logic [2:0] WAIT_INIT = 3'(READ_LATENCY);
    localparam logic [3:0] ATT_LIMIT = 4'(RETRY_MAX);

    sysid_state_t state_q, state_d;
    logic [2:0]   wait_q, wait_d;
    logic [3:0]   att_q, att_d, att_inc;
    logic         id_ok_q, id_ok_d, ts_ok_q, ts_ok_d;
    logic [31:0]  id_val_q, id_val_d, ts_val_q, ts_val_d;
    logic         addr_q, addr_d;
    logic         id_match, ts_match;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            wait_q   <= 3'd0;
            att_q    <= 4'd0;
            id_ok_q  <= 1'b0;
            ts_ok_q  <= 1'b0;
            id_val_q <= 32'd0;
            ts_val_q <= 32'd0;
            addr_q   <= SYSID_ADDR_ID;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            att_q    <= att_d;
            id_ok_q  <= id_ok_d;
            ts_ok_q  <= ts_ok_d;
            id_val_q <= id_val_d;
            ts_val_q <= ts_val_d;
            addr_q   <= addr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        att_d    = att_q;
        id_ok_d  = id_ok_q;
        ts_ok_d  = ts_ok_q;
        id_val_d = id_val_q;
        ts_val_d = ts_val_q;
        att_inc  = att_q + 4'd1;
        id_match = (id_val_q == EXPECTED_ID);
        ts_match = (ts_val_q == EXPECTED_TIMESTAMP);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RD_ID;
                    att_d   = 4'd0;
                    id_ok_d = 1'b0;
                    ts_ok_d = 1'b0;
                    wait_d  = WAIT_INIT;
                end
            end
            ST_RD_ID: begin
                if (wait_q != 3'd0) begin
                    wait_d = wait_q - 3'd1;
                end else begin
                    id_val_d = sysid_readdata;
                    wait_d   = WAIT_INIT;
                    state_d  = ST_RD_TS;
                end
            end
            ST_RD_TS: begin
                if (wait_q != 3'd0) begin
                    wait_d = wait_q - 3'd1;
                end else begin
                    ts_val_d = sysid_readdata;
                    wait_d   = WAIT_INIT;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                id_ok_d = id_match;
                ts_ok_d = ts_match;
                att_d   = att_inc;
                // att_inc is the pass count including the one just finished
                if ((id_match && ts_match) || (att_inc == ATT_LIMIT)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RD_ID;
                    wait_d  = WAIT_INIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered address leads the read state so the slave sees it in that same cycle.
        addr_d = (state_d == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    end

    assign sysid_address = addr_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign id_ok         = id_ok_q;
    assign ts_ok         = ts_ok_q;
    assign id_value      = id_val_q;
    assign ts_value      = ts_val_q;
    assign attempts      = att_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_kernel_sysid_checker.sv
// Bench for kernel_sysid_checker: two instances (latency 0 and 2) against a
// pass/position-based reference model, plus directed literal expectations.
module tb_kernel_sysid_checker;
    import kernel_sysid_pkg::*;

    localparam logic [31:0] EID  = 32'd2;
    localparam logic [31:0] ETS  = 32'd1504027687;
    localparam int          RMAX = 3;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b0;
    logic         start   = 1'b0;
    logic [31:0]  id_word = EID;
    logic [31:0]  ts_word = ETS;

    logic         addr      [2];
    logic [31:0]  rdata     [2];
    logic         busy      [2];
    logic         done      [2];
    logic         id_ok     [2];
    logic         ts_ok     [2];
    logic [31:0]  id_value  [2];
    logic [31:0]  ts_value  [2];
    logic [3:0]   attempts  [2];
    sysid_state_t fsm_state [2];

    // Combinational sysid slave model.
    assign rdata[0] = addr[0] ? ts_word : id_word;
    assign rdata[1] = addr[1] ? ts_word : id_word;

    kernel_sysid_checker #(
        .EXPECTED_ID(EID), .EXPECTED_TIMESTAMP(ETS), .READ_LATENCY(0), .RETRY_MAX(RMAX)
    ) u_dut_l0 (
        .clock(clock), .reset_n(reset_n), .start(start),
        .sysid_address(addr[0]), .sysid_readdata(rdata[0]),
        .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]),
        .id_value(id_value[0]), .ts_value(ts_value[0]), .attempts(attempts[0]),
        .fsm_state(fsm_state[0])
    );

    kernel_sysid_checker #(
        .EXPECTED_ID(EID), .EXPECTED_TIMESTAMP(ETS), .READ_LATENCY(2), .RETRY_MAX(RMAX)
    ) u_dut_l2 (
        .clock(clock), .reset_n(reset_n), .start(start),
        .sysid_address(addr[1]), .sysid_readdata(rdata[1]),
        .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]),
        .id_value(id_value[1]), .ts_value(ts_value[1]), .attempts(attempts[1]),
        .fsm_state(fsm_state[1])
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;
    int e0    = 1000000;
    int done_cnt [2];
    int done_at  [2];
    logic addr_trace [16];

    // ---------------- reference model ----------------
    // A check is a sequence of passes of 3+2L cycles; position c (1-based) in a
    // pass reads ID for c<=L+1, timestamp for L+2..2L+2, compares at c=3+2L.
    bit          m_act  [2];
    bit          m_done [2];
    bit          m_idok [2];
    bit          m_tsok [2];
    int          m_c    [2];
    int          m_att  [2];
    logic [31:0] m_idv  [2];
    logic [31:0] m_tsv  [2];

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic bit m_addr(input int i);
        int l;
        l = lat_of(i);
        return m_act[i] && !m_done[i] && (m_c[i] >= l + 2) && (m_c[i] <= 2 * l + 2);
    endfunction

    task automatic model_step(input int i);
        int l, p;
        l = lat_of(i);
        p = 3 + 2 * l;
        if (!reset_n) begin
            m_act[i] = 0; m_done[i] = 0; m_c[i] = 0; m_att[i] = 0;
            m_idok[i] = 0; m_tsok[i] = 0; m_idv[i] = 0; m_tsv[i] = 0;
        end else if (m_done[i]) begin
            m_done[i] = 0;
            m_act[i]  = 0;
        end else if (!m_act[i]) begin
            if (start) begin
                m_act[i] = 1; m_c[i] = 1; m_att[i] = 0; m_idok[i] = 0; m_tsok[i] = 0;
            end
        end else begin
            if (m_c[i] == l + 1)     m_idv[i] = id_word;
            if (m_c[i] == 2 * l + 2) m_tsv[i] = ts_word;
            if (m_c[i] == p) begin
                m_att[i]  = m_att[i] + 1;
                m_idok[i] = (m_idv[i] == EID);
                m_tsok[i] = (m_tsv[i] == ETS);
                if ((m_idok[i] && m_tsok[i]) || m_att[i] == RMAX) m_done[i] = 1;
                else m_c[i] = 1;
            end else begin
                m_c[i] = m_c[i] + 1;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare current outputs to the model, then advance the model over the coming edge.
    always @(negedge clock) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                int rel;
                rel = cyc - e0 + 1;
                chk($sformatf("busy[%0d]", i),     busy[i],     m_act[i]);
                chk($sformatf("done[%0d]", i),     done[i],     m_done[i]);
                chk($sformatf("addr[%0d]", i),     addr[i],     m_addr(i));
                chk($sformatf("id_ok[%0d]", i),    id_ok[i],    m_idok[i]);
                chk($sformatf("ts_ok[%0d]", i),    ts_ok[i],    m_tsok[i]);
                chk($sformatf("id_value[%0d]", i), id_value[i], m_idv[i]);
                chk($sformatf("ts_value[%0d]", i), ts_value[i], m_tsv[i]);
                chk($sformatf("attempts[%0d]", i), attempts[i], m_att[i]);
                chk($sformatf("idle[%0d]", i),     fsm_state[i] == ST_IDLE, !m_act[i]);
                if (done[i]) begin
                    done_cnt[i]++;
                    if (done_at[i] == 0) done_at[i] = rel;
                end
                if (i == 1 && rel >= 1 && rel <= 15) addr_trace[rel] = addr[1];
            end
        end
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Raise start for edge 0; returns in cycle 1.
    task automatic kick();
        done_cnt = '{0, 0};
        done_at  = '{0, 0};
        for (int k = 0; k < 16; k++) addr_trace[k] = 1'bx;
        start = 1'b1;
        e0    = cyc + 1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [31:0] pick(input logic [31:0] good);
        case ($urandom_range(0, 5))
            0:       return good ^ (32'd1 << $urandom_range(0, 31));
            1:       return $urandom;
            default: return good;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        done_cnt = '{0, 0};
        done_at  = '{0, 0};
        idle(3);
        armed = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_busy", busy[i], 0);
            chk("reset_attempts", attempts[i], 0);
            chk("reset_id_value", id_value[i], 0);
        end
        reset_n = 1'b1;
        idle(2);

        // Matching slave: one pass.
        kick();
        idle(30);
        chk("s1_done_cycle_l0", done_at[0], 4);
        chk("s1_id_ok_l0", id_ok[0], 1);
        chk("s1_ts_ok_l0", ts_ok[0], 1);
        chk("s1_attempts_l0", attempts[0], 1);
        chk("s1_done_cycle_l2", done_at[1], 8);
        for (int k = 1; k <= 8; k++)
            chk($sformatf("s1_addr_l2_c%0d", k), addr_trace[k], (k >= 4 && k <= 6) ? 1 : 0);

        // Timestamp off by one: every pass fails.
        ts_word = ETS + 32'd1;
        kick();
        idle(30);
        chk("s2_done_cycle_l0", done_at[0], 10);
        chk("s2_id_ok_l0", id_ok[0], 1);
        chk("s2_ts_ok_l0", ts_ok[0], 0);
        chk("s2_attempts_l0", attempts[0], 3);
        chk("s2_ts_value_l0", ts_value[0], 32'd1504027688);
        chk("s2_done_cycle_l2", done_at[1], 22);
        chk("s2_attempts_l2", attempts[1], 3);
        ts_word = ETS;

        // ID wrong on the first read only.
        id_word = 32'd5;
        kick();
        step();
        id_word = EID;
        idle(30);
        chk("s3_done_cycle_l0", done_at[0], 7);
        chk("s3_id_ok_l0", id_ok[0], 1);
        chk("s3_attempts_l0", attempts[0], 2);
        chk("s3_done_cycle_l2", done_at[1], 8);
        chk("s3_attempts_l2", attempts[1], 1);

        // Reset while the latency-0 instance is in RD_TS.
        kick();
        step();
        reset_n = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            chk("s4_busy", busy[i], 0);
            chk("s4_done", done[i], 0);
            chk("s4_addr", addr[i], 0);
            chk("s4_id_ok", id_ok[i], 0);
            chk("s4_ts_ok", ts_ok[i], 0);
            chk("s4_attempts", attempts[i], 0);
            chk("s4_id_value", id_value[i], 0);
            chk("s4_ts_value", ts_value[i], 0);
        end
        reset_n = 1'b1;
        idle(20);
        chk("s4_no_done_l0", done_cnt[0], 0);
        chk("s4_no_done_l2", done_cnt[1], 0);
        kick();
        idle(30);
        chk("s4_restart_done_cycle_l0", done_at[0], 4);
        chk("s4_restart_attempts_l0", attempts[0], 1);

        // Start pulsed again while busy is ignored.
        kick();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        idle(30);
        chk("s5_attempts_l0", attempts[0], 1);
        chk("s5_attempts_l2", attempts[1], 1);
        chk("s5_done_count_l0", done_cnt[0], 1);
        chk("s5_done_count_l2", done_cnt[1], 1);

        // Randomized traffic, including held start and occasional resets.
        repeat (3000) begin
            step();
            start   = ($urandom_range(0, 3) == 0);
            reset_n = ($urandom_range(0, 149) != 0);
            id_word = pick(EID);
            ts_word = pick(ETS);
        end
        step();
        start   = 1'b0;
        reset_n = 1'b1;
        id_word = EID;
        ts_word = ETS;
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kernel_sysid_checker.md
# kernel_sysid_checker

Boot-time consumer of the system-ID slave. On `start`, it reads the ID word (address 0) and the timestamp word (address 1) over the slave's 1-bit-address read port and compares both against build-time expected values. It retries a bounded number of times on mismatch and reports pass/fail flags plus the captured words to the kernel's control/status logic. It sits directly downstream of the sysid slave and drives that slave's `address` input.

## Interface
- `EXPECTED_ID`, 2, expected word at address 0
- `EXPECTED_TIMESTAMP`, 1504027687, expected word at address 1
- `READ_LATENCY`, 0, cycles between driving `sysid_address` and sampling `sysid_readdata` (0 = combinational slave); range 0..7
- `RETRY_MAX`, 3, total read passes allowed before reporting failure; range 1..15

Ports:
- `clock`  in  1  single clock; all logic on rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `start`  in  1  begin check; sampled only in IDLE
- `sysid_address`  out  1  drives the sysid slave address
- `sysid_readdata`  in  32  sysid slave read data
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when the check completes
- `id_ok`  out  1  last captured ID == `EXPECTED_ID`
- `ts_ok`  out  1  last captured timestamp == `EXPECTED_TIMESTAMP`
- `id_value`  out  32  last captured ID word
- `ts_value`  out  32  last captured timestamp word
- `attempts`  out  4  passes executed in the current or last check

## Operation
- States: IDLE, RD_ID, RD_TS, CHECK, DONE.
- IDLE: `start`=1 → RD_ID. Same edge: clear `attempts`, `id_ok`, `ts_ok`; load the wait counter with `READ_LATENCY`.
- RD_ID: `sysid_address`=0.
  - Counter ≠ 0: decrement.
  - Counter = 0: capture `sysid_readdata` into `id_value`, reload the counter, go to RD_TS.
- RD_TS: `sysid_address`=1. Same counting rule; on capture, write `ts_value` and go to CHECK.
- CHECK: register `id_ok`/`ts_ok` from the 32-bit equality compares (full width, unsigned) and increment `attempts`.
  - Both ok, or incremented `attempts` == `RETRY_MAX` → DONE.
  - Otherwise → RD_ID with the counter reloaded.
- DONE: `done`=1 for exactly this cycle, then → IDLE.
- `start` outside IDLE is ignored. `start` held high in IDLE retriggers after DONE.
- Outputs `id_ok`, `ts_ok`, `id_value`, `ts_value`, `attempts` hold their values until the next accepted `start`.
- `sysid_address` is registered. It holds 0 in IDLE, CHECK and DONE.

## Timing
- Reset (`reset_n`=0 at an edge) puts every output at 0 after that edge: `busy`, `done`, `sysid_address`, `id_ok`, `ts_ok`, `attempts`, `id_value`, `ts_value`. State → IDLE.
- Reset mid-operation aborts without a `done` pulse. Operation resumes only on a new `start` after `reset_n` returns high.
- One pass = 3 + 2·`READ_LATENCY` cycles.
- With `start` sampled at edge 0 and N passes, `done` is high in cycle N·(3 + 2·`READ_LATENCY`) + 1.
- `READ_LATENCY`=0: `readdata` is sampled in the same cycle `sysid_address` is driven, so the slave must be combinational.

## Structure
- Shared package `kernel_sysid_pkg`:
  - state enum
  - default `EXPECTED_ID` and `EXPECTED_TIMESTAMP` constants
  - `SYSID_ADDR_ID`=0, `SYSID_ADDR_TS`=1
- No sub-module. Single FSM with a 3-bit wait counter and a 4-bit attempts counter.

## Test plan
- Defaults, slave returns 2 / 1504027687, `start` at edge 0 → `done` in cycle 4, `id_ok`=`ts_ok`=1, `attempts`=1.
- Slave timestamp 1504027688, `RETRY_MAX`=3 → 3 passes, `done` in cycle 10, `id_ok`=1, `ts_ok`=0, `attempts`=3, `ts_value`=1504027688.
- ID reads 5 on pass 1 and 2 afterwards → `done` in cycle 7, `id_ok`=1, `attempts`=2.
- `READ_LATENCY`=2, matching slave → `sysid_address` 0 for cycles 1–3 and 1 for cycles 4–6, `done` in cycle 8.
- `reset_n`=0 during RD_TS → all outputs 0 next cycle, no `done`; re-issued `start` → normal pass.
- `start` pulsed during RD_ID → ignored, `attempts`=1, exactly one `done`.
